// File: rtl/sram_block_responder.sv
// Responder for the 128-bit block-SRAM strobe interface: strobe reads/writes, a zeroing init engine,
// and an optional word-dump engine enabled by defining SRAM_DUMP_EN.
module sram_block_responder #(
   parameter int WORDS  = 8,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sramread,
   input  logic              sramwrite,
   input  logic [ADDR_W-1:0] sramaddr,
   input  logic [127:0]      sramwrite_data,
   input  logic              sraminit,
   input  logic [2:0]        sraminitnum,
`ifdef SRAM_DUMP_EN
   input  logic              sramdump,
   input  logic [2:0]        sramdumpnum,
`endif
   output logic [127:0]      sramread_data,
   output logic              sram_rvalid,
   output logic              sram_busy,
   output logic              sram_err,
   output logic [127:0]      dump_data,
   output logic [ADDR_W-1:0] dump_addr,
   output logic              dump_valid
);

   localparam int MEM_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int IDX_W  = ADDR_W - 4;
   localparam logic [2:0] LAST_MAX = 3'(WORDS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_INIT = 2'd1;
   localparam logic [1:0] ST_DUMP = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [2:0]   cnt_q, cnt_d;
   logic [2:0]   last_q, last_d;
   logic [127:0] rdata_q, rdata_d;
   logic         rvalid_q, rvalid_d;
   logic         err_q, err_d;

   logic [127:0] mem_q [WORDS];
   logic              mem_we;
   logic [MEM_AW-1:0] mem_wa;
   logic [127:0]      mem_wd;

   logic              dump_req;
   logic [2:0]        dump_num;
   logic              addr_ok;
   logic [MEM_AW-1:0] req_idx;

`ifdef SRAM_DUMP_EN
   assign dump_req = sramdump;
   assign dump_num = sramdumpnum;
`else
   assign dump_req = 1'b0;
   assign dump_num = 3'd0;
`endif

   assign addr_ok = (sramaddr[3:0] == 4'd0) && (sramaddr[ADDR_W-1:4] < IDX_W'(WORDS));
   assign req_idx = sramaddr[4 +: MEM_AW];

   function automatic logic [2:0] clamp_last(input logic [2:0] n);
      return (n > LAST_MAX) ? LAST_MAX : n;
   endfunction

   always_comb begin
      // NOTE: every combinational output gets a default here, so no path through the case can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      mem_we   = 1'b0;
      mem_wa   = '0;
      mem_wd   = '0;

      case (state_q)
         ST_IDLE: begin
            if (sraminit) begin
               state_d = ST_INIT;
               cnt_d   = 3'd0;
               last_d  = clamp_last(sraminitnum);
               err_d   = sramread | sramwrite;
            end else if (dump_req) begin
               state_d = ST_DUMP;
               cnt_d   = 3'd0;
               last_d  = clamp_last(dump_num);
               err_d   = sramread | sramwrite;
            end else if (sramread && sramwrite) begin
               err_d = 1'b1;
            end else if (sramread || sramwrite) begin
               if (!addr_ok) begin
                  err_d = 1'b1;
               end else if (sramwrite) begin
                  mem_we = 1'b1;
                  mem_wa = req_idx;
                  mem_wd = sramwrite_data;
               end else begin
                  rdata_d  = mem_q[req_idx];
                  rvalid_d = 1'b1;
               end
            end
         end
         default: begin
            // Both engines walk words 0..last one per cycle; only INIT writes.
            err_d = sramread | sramwrite | sraminit | dump_req;
            if (state_q == ST_INIT) begin
               mem_we = 1'b1;
               mem_wa = cnt_q[MEM_AW-1:0];
            end
            if (cnt_q == last_q) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 3'd0;
         last_q   <= 3'd0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   // NOTE: the array is architecturally cleared by reset, so it is built from resettable flops, not a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[mem_wa] <= mem_wd;
      end
   end

   assign sramread_data = rdata_q;
   assign sram_rvalid   = rvalid_q;
   assign sram_err      = err_q;
   assign sram_busy     = (state_q != ST_IDLE);

`ifdef SRAM_DUMP_EN
   assign dump_valid = (state_q == ST_DUMP);
   assign dump_data  = dump_valid ? mem_q[cnt_q[MEM_AW-1:0]] : '0;
   assign dump_addr  = dump_valid ? ADDR_W'({cnt_q, 4'b0000}) : '0;
`else
   assign dump_valid = 1'b0;
   assign dump_data  = '0;
   assign dump_addr  = '0;
`endif

endmodule

// File: tb/tb_sram_block_responder.sv
// Self-checking bench for sram_block_responder: directed plan plus random strobes against a word-array model.
module tb_sram_block_responder;

   localparam int WORDS  = 8;
   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              sramread, sramwrite, sraminit;
   logic [ADDR_W-1:0] sramaddr;
   logic [127:0]      sramwrite_data;
   logic [2:0]        sraminitnum;
   logic              sramdump;
   logic [2:0]        sramdumpnum;
   logic [127:0]      sramread_data, dump_data;
   logic [ADDR_W-1:0] dump_addr;
   logic              sram_rvalid, sram_busy, sram_err, dump_valid;

   logic [127:0] model [WORDS];
   logic [127:0] exp_rdata;
   int vectors = 0;
   int miscompares = 0;

   sram_block_responder #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .sramread       (sramread),
      .sramwrite      (sramwrite),
      .sramaddr       (sramaddr),
      .sramwrite_data (sramwrite_data),
      .sraminit       (sraminit),
      .sraminitnum    (sraminitnum),
`ifdef SRAM_DUMP_EN
      .sramdump       (sramdump),
      .sramdumpnum    (sramdumpnum),
`endif
      .sramread_data  (sramread_data),
      .sram_rvalid    (sram_rvalid),
      .sram_busy      (sram_busy),
      .sram_err       (sram_err),
      .dump_data      (dump_data),
      .dump_addr      (dump_addr),
      .dump_valid     (dump_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One strobe cycle; the model decides acceptance from the address rules alone.
   task automatic do_op(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [127:0] data);
      int  idx;
      logic ok;
      idx = int'(addr) / 16;
      ok  = (rd != wr) && (addr % 16 == 0) && (idx < WORDS);
      sramread = rd; sramwrite = wr; sramaddr = addr; sramwrite_data = data;
      tick();
      sramread = 1'b0; sramwrite = 1'b0;
      if (ok && wr) model[idx] = data;
      if (ok && rd) exp_rdata = model[idx];
      check("err",    128'(sram_err),    128'(!ok));
      check("rvalid", 128'(sram_rvalid), 128'(ok && rd));
      check("rdata",  sramread_data,     exp_rdata);
   endtask

   task automatic read_all();
      for (int i = 0; i < WORDS; i++) do_op(1'b1, 1'b0, ADDR_W'(i * 16), '0);
   endtask

   task automatic fill_all();
      for (int i = 0; i < WORDS; i++)
         do_op(1'b0, 1'b1, ADDR_W'(i * 16), {$urandom, $urandom, $urandom, 32'(i + 1)});
   endtask

   initial begin
      rst = 1'b1; sramread = 0; sramwrite = 0; sraminit = 0; sramdump = 0;
      sramaddr = '0; sramwrite_data = '0; sraminitnum = '0; sramdumpnum = '0;
      for (int i = 0; i < WORDS; i++) model[i] = '0;
      exp_rdata = '0;
      tick(); tick();
      check("rst_rdata",  sramread_data,       '0);
      check("rst_rvalid", 128'(sram_rvalid),   '0);
      check("rst_busy",   128'(sram_busy),     '0);
      check("rst_err",    128'(sram_err),      '0);
      check("rst_dvalid", 128'(dump_valid),    '0);
      rst = 1'b0;
      tick();

      do_op(1'b0, 1'b1, 16'd16, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      do_op(1'b1, 1'b0, 16'd16, '0);
      do_op(1'b0, 1'b1, 16'd32, {16{8'hF5}});
      do_op(1'b1, 1'b0, 16'd32, '0);
      tick();
      check("rvalid_one_cycle", 128'(sram_rvalid), '0);
      do_op(1'b1, 1'b0, 16'd20,  '0);
      do_op(1'b1, 1'b0, 16'd128, '0);
      do_op(1'b1, 1'b1, 16'd16,  128'h1);
      do_op(1'b1, 1'b0, 16'd16,  '0);

      // Init of words 0..2 with a rejected read in the first busy cycle.
      fill_all();
      sraminit = 1'b1; sraminitnum = 3'd2;
      tick();
      sraminit = 1'b0;
      check("init_busy0", 128'(sram_busy), 128'(1));
      check("init_err0",  128'(sram_err),  '0);
      for (int c = 1; c <= 2; c++) begin
         if (c == 1) begin sramread = 1'b1; sramaddr = 16'd48; end
         tick();
         sramread = 1'b0;
         check("init_busy", 128'(sram_busy), 128'(1));
         if (c == 1) begin
            check("init_rd_err",    128'(sram_err),    128'(1));
            check("init_rd_rvalid", 128'(sram_rvalid), '0);
         end
      end
      tick();
      check("init_done", 128'(sram_busy), '0);
      for (int i = 0; i <= 2; i++) model[i] = '0;
      read_all();

`ifdef SRAM_DUMP_EN
      fill_all();
      sramdump = 1'b1; sramdumpnum = 3'd3;
      tick();
      sramdump = 1'b0;
      for (int i = 0; i <= 3; i++) begin
         check("dump_valid", 128'(dump_valid), 128'(1));
         check("dump_addr",  128'(dump_addr),  128'(i * 16));
         check("dump_data",  dump_data,        model[i]);
         tick();
      end
      check("dump_end_valid", 128'(dump_valid), '0);
      check("dump_end_busy",  128'(sram_busy),  '0);
`endif

      for (int n = 0; n < 300; n++) begin
         int kind;
         logic [ADDR_W-1:0] a;
         kind = int'($urandom_range(0, 9));
         a = ADDR_W'($urandom_range(0, 9) * 16);
         if ($urandom_range(0, 7) == 0) a = a | ADDR_W'($urandom_range(1, 15));
         if (kind < 4)      do_op(1'b0, 1'b1, a, {$urandom, $urandom, $urandom, $urandom});
         else if (kind < 9) do_op(1'b1, 1'b0, a, '0);
         else               do_op(1'b1, 1'b1, a, '0);
         if (n % 50 == 0) check("idle_dvalid", 128'(dump_valid), '0);
      end

      // Reset in the second INIT cycle clears everything asynchronously.
      fill_all();
      sraminit = 1'b1; sraminitnum = 3'd7;
      tick();
      sraminit = 1'b0;
      tick();
      check("mid_init_busy", 128'(sram_busy), 128'(1));
      rst = 1'b1;
      #1;
      check("arst_busy",   128'(sram_busy),   '0);
      check("arst_rdata",  sramread_data,     '0);
      check("arst_rvalid", 128'(sram_rvalid), '0);
      check("arst_err",    128'(sram_err),    '0);
      check("arst_dvalid", 128'(dump_valid),  '0);
      for (int i = 0; i < WORDS; i++) model[i] = '0;
      exp_rdata = '0;
      tick();
      rst = 1'b0;
      tick();
      read_all();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
